// File: rtl/imem_access_ctrl.sv
// Byte-serial instruction memory sequencer: arbitrates CPU fetches and loader writes
// onto one 8-bit memory port, four byte transfers per 32-bit little-endian word.
module imem_access_ctrl #(
    parameter int          MEM_BYTES = 100,
    parameter int          MA_W      = 7,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_req,
    input  logic [31:0]     fetch_addr,
    output logic            fetch_ack,
    output logic [31:0]     fetch_instr,
    output logic            fetch_err,
    input  logic            ld_req,
    input  logic [31:0]     ld_addr,
    input  logic [31:0]     ld_wdata,
    output logic            ld_ack,
    output logic            ld_err,
    output logic            cpu_stall,
    output logic            busy,
    output logic [MA_W-1:0] mem_addr,
    output logic            mem_we,
    output logic [7:0]      mem_wdata,
    input  logic [7:0]      mem_rdata
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [31:0] LAST_BASE = 32'(MEM_BYTES - 4);

    function automatic logic addr_bad(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr > LAST_BASE);
    endfunction

    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

    state_t          state_r, state_s;
    logic [1:0]      cnt_r, cnt_s;
    logic [31:0]     wdata_r, wdata_s;
    logic [31:0]     instr_r, instr_s;
    logic            fetch_ack_r, fetch_ack_s;
    logic            fetch_err_r, fetch_err_s;
    logic            ld_ack_r, ld_ack_s;
    logic            ld_err_r, ld_err_s;
    logic [MA_W-1:0] mem_addr_r, mem_addr_s;
    logic            mem_we_r, mem_we_s;
    logic [7:0]      mem_wdata_r, mem_wdata_s;
    logic            busy_r;

    // Next-state and next-output computation; every output is registered from these.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        wdata_s     = wdata_r;
        instr_s     = instr_r;
        fetch_ack_s = 1'b0;
        fetch_err_s = fetch_err_r;
        ld_ack_s    = 1'b0;
        ld_err_s    = ld_err_r;
        mem_addr_s  = mem_addr_r;
        mem_we_s    = 1'b0;
        mem_wdata_s = mem_wdata_r;
        case (state_r)
            IDLE: begin
                // Loader wins a tie; bad addresses skip the memory entirely.
                if (ld_req) begin
                    if (addr_bad(ld_addr)) begin
                        state_s  = DONE;
                        ld_ack_s = 1'b1;
                        ld_err_s = 1'b1;
                    end else begin
                        state_s     = WR;
                        cnt_s       = 2'd0;
                        wdata_s     = ld_wdata;
                        ld_err_s    = 1'b0;
                        mem_addr_s  = ld_addr[MA_W-1:0];
                        mem_we_s    = 1'b1;
                        mem_wdata_s = ld_wdata[7:0];
                    end
                end else if (fetch_req) begin
                    if (addr_bad(fetch_addr)) begin
                        state_s     = DONE;
                        fetch_ack_s = 1'b1;
                        fetch_err_s = 1'b1;
                        instr_s     = NOP_INSTR;
                    end else begin
                        state_s     = RD;
                        cnt_s       = 2'd0;
                        fetch_err_s = 1'b0;
                        mem_addr_s  = fetch_addr[MA_W-1:0];
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RD: begin
                instr_s[{cnt_r, 3'b000} +: 8] = mem_rdata;
                if (cnt_r == 2'd3) begin
                    state_s     = DONE;
                    fetch_ack_s = 1'b1;
                end else begin
                    cnt_s      = cnt_r + 2'd1;
                    mem_addr_s = mem_addr_r + MA_W'(1);
                end
            end
            WR: begin
                if (cnt_r == 2'd3) begin
                    state_s  = DONE;
                    ld_ack_s = 1'b1;
                end else begin
                    cnt_s       = cnt_r + 2'd1;
                    mem_addr_s  = mem_addr_r + MA_W'(1);
                    mem_we_s    = 1'b1;
                    mem_wdata_s = byte_sel(wdata_r, cnt_r + 2'd1);
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= 2'd0;
            wdata_r     <= 32'd0;
            instr_r     <= 32'd0;
            fetch_ack_r <= 1'b0;
            fetch_err_r <= 1'b0;
            ld_ack_r    <= 1'b0;
            ld_err_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_we_r    <= 1'b0;
            mem_wdata_r <= 8'd0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            wdata_r     <= wdata_s;
            instr_r     <= instr_s;
            fetch_ack_r <= fetch_ack_s;
            fetch_err_r <= fetch_err_s;
            ld_ack_r    <= ld_ack_s;
            ld_err_r    <= ld_err_s;
            mem_addr_r  <= mem_addr_s;
            mem_we_r    <= mem_we_s;
            mem_wdata_r <= mem_wdata_s;
            busy_r      <= (state_s != IDLE);
        end
    end

    assign fetch_ack   = fetch_ack_r;
    assign fetch_instr = instr_r;
    assign fetch_err   = fetch_err_r;
    assign ld_ack      = ld_ack_r;
    assign ld_err      = ld_err_r;
    assign mem_addr    = mem_addr_r;
    assign mem_we      = mem_we_r;
    assign mem_wdata   = mem_wdata_r;
    assign busy        = busy_r;
    assign cpu_stall   = fetch_req & ~fetch_ack_r;

endmodule

// File: tb/tb_imem_access_ctrl.sv
// Scoreboard bench for imem_access_ctrl with a behavioural byte memory on the port.
module tb_imem_access_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ack;
    logic [31:0] fetch_instr;
    logic        fetch_err;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic [31:0] ld_wdata;
    logic        ld_ack;
    logic        ld_err;
    logic        cpu_stall;
    logic        busy;
    logic [6:0]  mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic [7:0]  mem [0:127];
    logic        pre_we;
    logic [6:0]  pre_addr;
    logic [7:0]  pre_data;

    typedef struct {
        logic        is_ld;
        logic [31:0] instr;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [14:0] wr_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;

    imem_access_ctrl #(.MEM_BYTES(100), .MA_W(7), .NOP_INSTR(32'h0000_0013)) dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack),
        .fetch_instr(fetch_instr), .fetch_err(fetch_err),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_ack(ld_ack), .ld_err(ld_err),
        .cpu_stall(cpu_stall), .busy(busy),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    // Byte memory: DUT writes take precedence over bench preloads.
    always @(posedge clk) begin
        if (mem_we === 1'b1) mem[mem_addr] <= mem_wdata;
        else if (pre_we) mem[pre_addr] <= pre_data;
    end

    task automatic poke(input logic [6:0] a, input logic [7:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(posedge clk);
        #1;
        pre_we   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 128; i++) poke(7'(i), 8'h00);
        @(negedge clk);
        n_cmp++;
        if ({fetch_ack, fetch_instr, fetch_err, ld_ack, ld_err, mem_we, mem_addr, mem_wdata, busy} !== 53'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", {fetch_ack, fetch_instr, fetch_err, ld_ack, ld_err, mem_we, mem_addr, mem_wdata, busy});
        end
        n_cmp++;
        if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", cpu_stall); end
        reset = 1'b0;
    endtask

    task automatic test_fetch_basic();
        exp_t e;
        poke(7'd0, 8'h83); poke(7'd1, 8'h20); poke(7'd2, 8'h00); poke(7'd3, 8'h00);
        sb.push_back('{1'b0, 32'h0000_2083, 1'b0, 5});
        @(posedge clk); #1;
        fetch_addr = 32'd0;
        fetch_req  = 1'b1;
        for (int c = 0; c < 12 && sb.size() > 0; c++) begin
            @(negedge clk);
            n_cmp++;
            if (cpu_stall !== (c < 5)) begin n_fail++; $display("FAIL fetch_stall: cycle %0d got %b want %b", c, cpu_stall, (c < 5)); end
            n_cmp++;
            if (mem_we !== 1'b0) begin n_fail++; $display("FAIL fetch_no_we: cycle %0d got %b want 0", c, mem_we); end
            n_cmp++;
            if (busy !== (c >= 1)) begin n_fail++; $display("FAIL fetch_busy: cycle %0d got %b want %b", c, busy, (c >= 1)); end
            if (fetch_ack === 1'b1) begin
                e = sb.pop_front();
                fetch_req = 1'b0;
                n_cmp++;
                if (c !== e.cyc) begin n_fail++; $display("FAIL fetch_latency: got %0d want %0d", c, e.cyc); end
                n_cmp++;
                if (fetch_instr !== e.instr) begin n_fail++; $display("FAIL fetch_instr: got %h want %h", fetch_instr, e.instr); end
                n_cmp++;
                if (fetch_err !== e.err) begin n_fail++; $display("FAIL fetch_err: got %b want %b", fetch_err, e.err); end
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL fetch_timeout: pending %0d want 0", sb.size()); sb.delete(); end
        fetch_req = 1'b0;
    endtask

    task automatic test_load();
        exp_t e;
        logic [14:0] w;
        wr_q.push_back({7'd12, 8'hB3}); wr_q.push_back({7'd13, 8'h80});
        wr_q.push_back({7'd14, 8'h20}); wr_q.push_back({7'd15, 8'h02});
        sb.push_back('{1'b1, 32'h0, 1'b0, 5});
        sb.push_back('{1'b0, 32'h0220_80B3, 1'b0, 11});
        @(posedge clk); #1;
        ld_addr  = 32'd12;
        ld_wdata = 32'h0220_80B3;
        ld_req   = 1'b1;
        for (int c = 0; c < 20 && sb.size() > 0; c++) begin
            @(negedge clk);
            if (mem_we === 1'b1) begin
                n_cmp++;
                w = (wr_q.size() > 0) ? wr_q.pop_front() : 15'h7fff;
                if ({mem_addr, mem_wdata} !== w) begin n_fail++; $display("FAIL load_write: cycle %0d got %h want %h", c, {mem_addr, mem_wdata}, w); end
            end
            if (ld_ack === 1'b1 || fetch_ack === 1'b1) begin
                e = sb.pop_front();
                n_cmp++;
                if (ld_ack !== e.is_ld || fetch_ack !== !e.is_ld) begin n_fail++; $display("FAIL load_order: got ld=%b fe=%b want ld=%b", ld_ack, fetch_ack, e.is_ld); end
                n_cmp++;
                if (c !== e.cyc) begin n_fail++; $display("FAIL load_latency: got %0d want %0d", c, e.cyc); end
                if (e.is_ld) begin
                    n_cmp++;
                    if (ld_err !== 1'b0) begin n_fail++; $display("FAIL load_err: got %b want 0", ld_err); end
                    ld_req     = 1'b0;
                    fetch_addr = 32'd12;
                    fetch_req  = 1'b1;
                end else begin
                    n_cmp++;
                    if (fetch_instr !== e.instr) begin n_fail++; $display("FAIL load_readback: got %h want %h", fetch_instr, e.instr); end
                    fetch_req = 1'b0;
                end
            end
        end
        n_cmp++;
        if (sb.size() != 0 || wr_q.size() != 0) begin
            n_fail++; $display("FAIL load_timeout: pending acks %0d writes %0d want 0", sb.size(), wr_q.size());
            sb.delete(); wr_q.delete();
        end
        ld_req = 1'b0; fetch_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        sb.push_back('{1'b1, 32'h0, 1'b0, 5});
        sb.push_back('{1'b0, 32'h1122_3344, 1'b0, 11});
        @(posedge clk); #1;
        ld_addr    = 32'd16;
        ld_wdata   = 32'h1122_3344;
        fetch_addr = 32'd16;
        ld_req     = 1'b1;
        fetch_req  = 1'b1;
        for (int c = 0; c < 20 && sb.size() > 0; c++) begin
            @(negedge clk);
            if (ld_ack === 1'b1 || fetch_ack === 1'b1) begin
                e = sb.pop_front();
                n_cmp++;
                if (ld_ack !== e.is_ld || fetch_ack !== !e.is_ld) begin n_fail++; $display("FAIL b2b_order: got ld=%b fe=%b want ld=%b", ld_ack, fetch_ack, e.is_ld); end
                n_cmp++;
                if (c !== e.cyc) begin n_fail++; $display("FAIL b2b_latency: got %0d want %0d", c, e.cyc); end
                if (e.is_ld) begin
                    ld_req = 1'b0;
                end else begin
                    n_cmp++;
                    if (fetch_instr !== e.instr) begin n_fail++; $display("FAIL b2b_instr: got %h want %h", fetch_instr, e.instr); end
                    fetch_req = 1'b0;
                end
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL b2b_timeout: pending %0d want 0", sb.size()); sb.delete(); end
        ld_req = 1'b0; fetch_req = 1'b0;
    endtask

    task automatic test_errors();
        exp_t        e;
        logic        t_ld    [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] t_addr  [4] = '{32'd2, 32'd100, 32'd98, 32'd96};
        logic [31:0] t_instr [4] = '{32'h0000_0013, 32'h0000_0013, 32'h0, 32'h0010_0513};
        logic        t_err   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        int          t_cyc   [4] = '{1, 1, 1, 5};
        poke(7'd96, 8'h13); poke(7'd97, 8'h05); poke(7'd98, 8'h10); poke(7'd99, 8'h00);
        for (int t = 0; t < 4; t++) begin
            sb.push_back('{t_ld[t], t_instr[t], t_err[t], t_cyc[t]});
            @(posedge clk); #1;
            ld_addr    = t_addr[t];
            ld_wdata   = 32'hDEAD_BEEF;
            fetch_addr = t_addr[t];
            ld_req     = t_ld[t];
            fetch_req  = !t_ld[t];
            for (int c = 0; c < 10 && sb.size() > 0; c++) begin
                @(negedge clk);
                n_cmp++;
                if (mem_we !== 1'b0) begin n_fail++; $display("FAIL err_no_we: case %0d cycle %0d got %b want 0", t, c, mem_we); end
                if (ld_ack === 1'b1 || fetch_ack === 1'b1) begin
                    e = sb.pop_front();
                    n_cmp++;
                    if (c !== e.cyc) begin n_fail++; $display("FAIL err_latency: case %0d got %0d want %0d", t, c, e.cyc); end
                    n_cmp++;
                    if ((e.is_ld ? ld_err : fetch_err) !== e.err) begin n_fail++; $display("FAIL err_flag: case %0d got %b want %b", t, e.is_ld ? ld_err : fetch_err, e.err); end
                    if (!e.is_ld) begin
                        n_cmp++;
                        if (fetch_instr !== e.instr) begin n_fail++; $display("FAIL err_instr: case %0d got %h want %h", t, fetch_instr, e.instr); end
                    end
                    ld_req    = 1'b0;
                    fetch_req = 1'b0;
                end
            end
            n_cmp++;
            if (sb.size() != 0) begin n_fail++; $display("FAIL err_timeout: case %0d pending %0d want 0", t, sb.size()); sb.delete(); end
            ld_req = 1'b0; fetch_req = 1'b0;
        end
    endtask

    task automatic test_reset_mid_write();
        logic hit = 1'b0;
        @(posedge clk); #1;
        ld_addr  = 32'd0;
        ld_wdata = 32'hAABB_CCDD;
        ld_req   = 1'b1;
        for (int c = 0; c < 10 && !hit; c++) begin
            @(negedge clk);
            if (mem_we === 1'b1 && mem_addr === 7'd1) begin
                hit    = 1'b1;
                reset  = 1'b1;
                ld_req = 1'b0;
            end
        end
        n_cmp++;
        if (!hit) begin n_fail++; $display("FAIL midrst_timeout: got no second write want one"); end
        ld_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({fetch_ack, fetch_instr, fetch_err, ld_ack, ld_err, mem_we, mem_addr, mem_wdata, busy} !== 53'd0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got %h want 0", {fetch_ack, fetch_instr, fetch_err, ld_ack, ld_err, mem_we, mem_addr, mem_wdata, busy});
        end
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_cmp++;
            if (ld_ack !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL midrst_quiet: cycle %0d got ack=%b we=%b want 0", c, ld_ack, mem_we); end
        end
        n_cmp++;
        if ({mem[0], mem[1], mem[2], mem[3]} !== 32'hDDCC_0000) begin
            n_fail++; $display("FAIL midrst_bytes: got %h want ddcc0000", {mem[0], mem[1], mem[2], mem[3]});
        end
    endtask

    initial begin
        reset      = 1'b1;
        fetch_req  = 1'b0;
        fetch_addr = 32'd0;
        ld_req     = 1'b0;
        ld_addr    = 32'd0;
        ld_wdata   = 32'd0;
        pre_we     = 1'b0;
        pre_addr   = 7'd0;
        pre_data   = 8'd0;
        test_reset();
        test_fetch_basic();
        test_load();
        test_back_to_back();
        test_errors();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_access_ctrl.md
Name: imem_access_ctrl

Overview:
Sequencing controller for the byte-addressable instruction memory.
- Shares the single byte-wide memory port between two requesters:
  - the CPU fetch path, which reads 32-bit instructions;
  - a program loader, which writes 32-bit words.
- Reads and writes each take four byte transfers. Instruction bytes are assembled little-endian, so address+3 holds the MSB.
- Replaces reset-time hard-coded program loading with a runtime loader, and stalls the CPU while fetches are pending.

Parameters:
- MEM_BYTES, 100: memory depth in bytes. The last valid word base is MEM_BYTES-4.
- MA_W, 7: memory byte-address width. Must satisfy 2**MA_W >= MEM_BYTES.
- NOP_INSTR, 32'h00000013: instruction returned on a fetch error (addi x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- fetch_req  in  1  CPU fetch request. Held high until fetch_ack.
- fetch_addr  in  32  byte address of the fetch (PC). Held stable while fetch_req is high.
- fetch_ack  out  1  one-cycle pulse; fetch_instr and fetch_err are valid during it.
- fetch_instr  out  32  assembled instruction {b3,b2,b1,b0}.
- fetch_err  out  1  fetch address misaligned or out of range.
- ld_req  in  1  loader write request. Held high until ld_ack.
- ld_addr  in  32  byte address of the loader write.
- ld_wdata  in  32  word to write. Byte 0 is bits [7:0] and goes to ld_addr.
- ld_ack  out  1  one-cycle completion pulse.
- ld_err  out  1  loader address misaligned or out of range. No bytes are written.
- cpu_stall  out  1  equals fetch_req & ~fetch_ack (combinational).
- busy  out  1  high in any state other than IDLE.
- mem_addr  out  MA_W  byte address to the memory.
- mem_we  out  1  byte write strobe to the memory.
- mem_wdata  out  8  write byte.
- mem_rdata  in  8  read byte. Asynchronous: reflects mem_addr within the same cycle.

Behaviour:
- Reset values (applied at the clock edge where reset=1):
  - state=IDLE, byte counter=0;
  - fetch_ack=0, fetch_instr=0, fetch_err=0, ld_ack=0, ld_err=0;
  - mem_we=0, mem_addr=0, mem_wdata=0, busy=0.
- States: IDLE, RD, WR, DONE.
- IDLE, arbitration at each edge:
  - ld_req=1 has priority over fetch_req=1, and wins if both are high on the same edge.
  - The winner's address and data are latched.
  - No preemption once a transaction has started.
- Address check at acceptance. A request is in error if addr[1:0]!=0 or addr > MEM_BYTES-4.
  - Error case: go straight to DONE with the err bit set. fetch_instr=NOP_INSTR. No mem_we.
  - Error latency: ack in the cycle after acceptance.
- RD, four cycles, counter k=0..3:
  - mem_addr = base+k, mem_we=0.
  - At each edge, mem_rdata is captured into fetch_instr[8k+7:8k].
  - After k=3, go to DONE.
- WR, four cycles, counter k=0..3:
  - mem_addr = base+k, mem_we=1, mem_wdata = ld_wdata[8k+7:8k].
  - After k=3, go to DONE.
- DONE, one cycle:
  - Pulse the corresponding ack. The err bit is valid during this cycle.
  - fetch_instr holds its value until the next fetch is accepted.
  - Unconditionally go to IDLE.
  - The requester drops req after seeing ack; a req still high in IDLE is treated as a new request.
- Latency: request sampled at edge E, ack high in cycle E+5. Peak throughput is one transaction per 6 cycles.
- Idle port: mem_we=0 in every state except WR. mem_addr holds its last value when unused.
- Reset mid-transaction:
  - Aborts immediately with no ack.
  - In WR, bytes already written stay written and the rest are not written.
  - The requester must reissue the request.
- Requests deasserted mid-transaction are ignored. The transaction completes and its ack is still pulsed.

Test Plan:
- Preload bytes 0..3 = 83,20,00,00. Raise fetch_req with fetch_addr=0. Expect ack at cycle 5 with fetch_instr=32'h00002083, fetch_err=0, and cpu_stall=1 for cycles 0..4.
- Loader writes ld_addr=12, ld_wdata=32'h022080B3. Expect mem_we for 4 cycles with bytes B3,80,20,02 at addresses 12..15, then ld_ack. Then fetch 12 and expect 32'h022080B3.
- Raise ld_req and fetch_req on the same edge. Expect ld_ack first, at cycle 5, and fetch_ack at cycle 11.
- Fetch at address 2, then at address 100. Each gives fetch_ack the next cycle with fetch_err=1 and fetch_instr=32'h00000013, with no mem_we. Fetch at 96 succeeds.
- Assert reset after 2 WR bytes of 32'hAABBCCDD to address 0. Expect bytes 0,1 = DD,CC, bytes 2,3 unchanged, no ld_ack, and all outputs at reset values.
